// File: rtl/systolic_ctrl.sv
// systolic_ctrl
// Sequencer for a 2x2 weight-stationary systolic array. Accepts a job
// (four weights plus a vector count), pulses the array's weight load, then
// streams input vectors with a one-cycle skew between row 1 and row 2.
// The two column outputs are realigned and emitted as one result per
// accepted vector, in input order, followed by a one-cycle done pulse.
//
// Ports
//   clk, rst                     clock, async active-low reset
//   cfg_valid/cfg_ready          job handshake (ready only while idle)
//   cfg_w11..cfg_w22, cfg_count  job weights and number of vectors
//   in_valid/in_ready            input vector handshake
//   in_x1, in_x2                 vector elements (row 1, row 2)
//   res_valid, res_y1, res_y2    result pulse (no back-pressure)
//   done                         one-cycle pulse at job end
//   abort                        synchronous flush back to idle
//   arr_*                        array control, weights, skewed inputs
//   arr_out_21, arr_out_22       array column outputs
module systolic_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_w11,
  input  logic [DATA_W-1:0] cfg_w12,
  input  logic [DATA_W-1:0] cfg_w21,
  input  logic [DATA_W-1:0] cfg_w22,
  input  logic [CNT_W-1:0]  cfg_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x1,
  input  logic [DATA_W-1:0] in_x2,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_y1,
  output logic [DATA_W-1:0] res_y2,
  output logic              done,
  input  logic              abort,
  output logic              arr_start,
  output logic              arr_load_weights,
  output logic [DATA_W-1:0] arr_weight_11,
  output logic [DATA_W-1:0] arr_weight_12,
  output logic [DATA_W-1:0] arr_weight_21,
  output logic [DATA_W-1:0] arr_weight_22,
  output logic [DATA_W-1:0] arr_input_11,
  output logic [DATA_W-1:0] arr_input_21,
  input  logic [DATA_W-1:0] arr_out_21,
  input  logic [DATA_W-1:0] arr_out_22
);

  // Tag stages: [0] input row-1 cycle ... [STAGES] result cycle.
  localparam int STAGES = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_FIN    = 3'd4
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] w11;
    logic [DATA_W-1:0] w12;
    logic [DATA_W-1:0] w21;
    logic [DATA_W-1:0] w22;
  } wgt_t;

  state_t            state_q, state_d;
  wgt_t              wgt_q, wgt_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [STAGES:0]   vld_pipe_q, vld_pipe_d;
  logic [DATA_W-1:0] in11_q, in11_d;   // row-1 input, one cycle after accept
  logic [DATA_W-1:0] x2_stg_q, x2_stg_d; // row-2 element waiting one cycle
  logic [DATA_W-1:0] in21_q, in21_d;   // row-2 input, two cycles after accept
  logic [DATA_W-1:0] d21_q, d21_d;     // column-1 output delayed to meet column 2
  logic [DATA_W-1:0] y1_q, y1_d;
  logic [DATA_W-1:0] y2_q, y2_d;

  logic cfg_acc, in_acc;

  assign cfg_ready        = (state_q == S_IDLE);
  assign in_ready         = (state_q == S_STREAM);
  assign arr_start        = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign arr_load_weights = (state_q == S_LOAD);
  assign done             = (state_q == S_FIN);

  // abort beats any handshake in the same cycle
  assign cfg_acc = cfg_valid && cfg_ready && !abort;
  assign in_acc  = in_valid && in_ready && !abort;

  assign arr_weight_11 = wgt_q.w11;
  assign arr_weight_12 = wgt_q.w12;
  assign arr_weight_21 = wgt_q.w21;
  assign arr_weight_22 = wgt_q.w22;
  assign arr_input_11  = in11_q;
  assign arr_input_21  = in21_q;
  assign res_valid     = vld_pipe_q[STAGES];
  assign res_y1        = y1_q;
  assign res_y2        = y2_q;

  always_comb begin
    state_d    = state_q;
    wgt_d      = wgt_q;
    rem_d      = rem_q;
    y1_d       = y1_q;
    y2_d       = y2_q;

    // Bubbles shift zeros through the skew path and a 0 tag through the
    // tag pipe, so they never reach res_valid.
    vld_pipe_d = {vld_pipe_q[STAGES-1:0], in_acc};
    in11_d     = in_acc ? in_x1 : '0;
    x2_stg_d   = in_acc ? in_x2 : '0;
    in21_d     = x2_stg_q;
    d21_d      = arr_out_21;

    // Tag in its last pre-result stage: column 2 is valid now and the
    // delayed column-1 value belongs to the same vector.
    if (vld_pipe_q[STAGES-1]) begin
      y1_d = d21_q;
      y2_d = arr_out_22;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cfg_acc) begin
          wgt_d   = '{w11: cfg_w11, w12: cfg_w12, w21: cfg_w21, w22: cfg_w22};
          rem_d   = cfg_count;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d = (rem_q != '0) ? S_STREAM : S_FIN;
      end
      S_STREAM: begin
        if (in_acc) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leave once no tag is left ahead of the result stage; the last
        // result is then on the outputs and done lands one cycle later.
        if (vld_pipe_q[STAGES-1:0] == '0) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      vld_pipe_d = '0;
      in11_d     = '0;
      x2_stg_d   = '0;
      in21_d     = '0;
      d21_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      wgt_q      <= '0;
      rem_q      <= '0;
      vld_pipe_q <= '0;
      in11_q     <= '0;
      x2_stg_q   <= '0;
      in21_q     <= '0;
      d21_q      <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
    end else begin
      state_q    <= state_d;
      wgt_q      <= wgt_d;
      rem_q      <= rem_d;
      vld_pipe_q <= vld_pipe_d;
      in11_q     <= in11_d;
      x2_stg_q   <= x2_stg_d;
      in21_q     <= in21_d;
      d21_q      <= d21_d;
      y1_q       <= y1_d;
      y2_q       <= y2_d;
    end
  end

endmodule
